stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 SHALL have parameter DEPTH, default 512, meaning stack RAM entries; ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 3, opcode; cmd_data in WIDTH, operand.
REQ-005 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_data out WIDTH; rsp_err out 1, op rejected.
REQ-006 SHALL have ports: stk_delta out 2, pointer step; stk_we out 1; stk_wd out WIDTH; stk_rd in WIDTH, stack top-of-stack (TOS) read data.
REQ-007 SHALL have ports: depth out ADDR_WIDTH+1, current entries; overflow out 1, sticky; underflow out 1, sticky; busy out 1.

Function
REQ-008 SHALL use stk_delta encoding: 00 hold, 01 +1, 11 -1, 10 -2; stk_we writes stk_wd at the post-step pointer in the same cycle.
REQ-009 SHALL treat stk_rd as valid only in a cycle after a cycle with stk_delta=00 and stk_we=0; otherwise insert one SETTLE cycle before sampling.
REQ-010 SHALL limit capacity to DEPTH-1 entries (pointer 0 = empty sentinel).
REQ-011 SHALL drive stk_delta=00, stk_we=0 in every cycle not issuing a stack step.
REQ-012 SHALL accept a command on cmd_valid&&cmd_ready; cmd_ready=1 only in IDLE.
REQ-013 SHALL implement these opcodes: 0 NOP; 1 PUSH; 2 POP; 3 PEEK; 4 REPLACE; 5 DUP; 6 SWAP; 7 DROP2.
REQ-014 SHALL execute PUSH as delta 01, we, wd=cmd_data, depth+1, in the accept cycle.
REQ-015 SHALL execute REPLACE as delta 00, we, wd=cmd_data; depth unchanged.
REQ-016 SHALL execute POP as follows: capture TOS (after SETTLE if needed), issue delta 11, depth-1, then enter RSP with rsp_data=TOS.
REQ-017 SHALL execute PEEK as: capture TOS, enter RSP; no stack step.
REQ-018 SHALL execute DUP as: capture TOS, issue delta 01, we, wd=TOS.
REQ-019 SHALL execute SWAP as: capture A=TOS; delta 11; SETTLE; capture B; delta 00, we, wd=A; delta 01, we, wd=B; net depth unchanged.
REQ-020 SHALL execute DROP2 as delta 10, depth-2, single cycle.
REQ-021 SHALL use FSM states IDLE, SETTLE, CAPT, SWAP_POP, SWAP_SETTLE, SWAP_REP, SWAP_PUSH, RSP; busy=1 in every state except IDLE.
REQ-022 SHALL hold rsp_valid and rsp_data stable in RSP until rsp_ready, then return to IDLE.
REQ-023 SHALL reject PUSH/DUP when depth==DEPTH-1: no stack step, overflow<=1.
REQ-024 SHALL reject POP/PEEK/DUP when depth==0, and SWAP/DROP2 when depth<2: no stack step, underflow<=1.
REQ-025 SHALL answer rejected POP/PEEK with RSP carrying rsp_err=1, rsp_data=0; other rejected ops return to IDLE with no response.
REQ-026 SHALL keep overflow/underflow set until reset.

Reset
REQ-027 SHALL, on rst, force the FSM to IDLE and zero depth, overflow, underflow, rsp_valid, rsp_err, rsp_data, stk_we, stk_delta and stk_wd, and force cmd_ready=1 and busy=0 in the following cycle.
REQ-028 SHALL, on rst mid-operation, abandon the operation with no further stack step; the stack pointer is resynchronised by the external reset of the stack.

Structure
REQ-029 SHALL place opcode constants and FSM state encodings in shared package stack_pkg, reused by the CPU decoder.
REQ-030 SHALL be a single module with no sub-modules; bench pairs it with the existing RAM-backed stack.

Verification
REQ-031 SHALL cover: PUSH 0x1111, PUSH 0x2222, POP -> rsp_data=0x2222, rsp_err=0, depth 1.
REQ-032 SHALL cover: PUSH 0xA, PUSH 0xB, SWAP, POP, POP -> responses 0xA then 0xB, depth 0.
REQ-033 SHALL cover: POP at depth 0 -> rsp_err=1, rsp_data=0, underflow=1, stk_delta stays 00.
REQ-034 SHALL cover: DEPTH=8, 7 PUSHes then PUSH -> overflow=1, depth 7, no stk_we.
REQ-035 SHALL cover: PUSH 0x5, PEEK with rsp_ready low 4 cycles -> rsp_valid/rsp_data=0x5 held, cmd_ready=0 throughout.
REQ-036 SHALL cover: rst asserted during SWAP_SETTLE -> next cycle IDLE, depth 0, busy 0, no stk_we.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcode, FSM state and stack-step encodings for the stack sequencer
// and the CPU decoder that drives it.
package stack_pkg;

    // Command opcodes
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_PEEK    = 3'd3;
    localparam logic [2:0] OP_REPLACE = 3'd4;
    localparam logic [2:0] OP_DUP     = 3'd5;
    localparam logic [2:0] OP_SWAP    = 3'd6;
    localparam logic [2:0] OP_DROP2   = 3'd7;

    // Sequencer FSM state encodings
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SETTLE      = 3'd1;
    localparam logic [2:0] ST_CAPT        = 3'd2;
    localparam logic [2:0] ST_SWAP_POP    = 3'd3;
    localparam logic [2:0] ST_SWAP_SETTLE = 3'd4;
    localparam logic [2:0] ST_SWAP_REP    = 3'd5;
    localparam logic [2:0] ST_SWAP_PUSH   = 3'd6;
    localparam logic [2:0] ST_RSP         = 3'd7;

    // Stack pointer step encodings
    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_INC  = 2'b01;
    localparam logic [1:0] DELTA_DEC  = 2'b11;
    localparam logic [1:0] DELTA_DEC2 = 2'b10;

endpackage

// File: rtl/stack_sequencer.sv
// Command sequencer for a RAM-backed hardware stack. Turns stack opcodes
// into pointer steps/writes, honours the one-cycle read settling rule of
// the stack RAM and returns POP/PEEK results through a response handshake.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            stk_delta,
    output logic                  stk_we,
    output logic [WIDTH-1:0]      stk_wd,
    input  logic [WIDTH-1:0]      stk_rd,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] MAX_FILL = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] D_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] D_TWO    = (ADDR_WIDTH+1)'(2);

    logic [2:0]          r_state;
    logic [2:0]          r_op;
    logic [ADDR_WIDTH:0] r_depth;
    logic                r_quiet;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_ovf;
    logic                r_unf;
    logic [WIDTH-1:0]    r_rsp_data;
    logic                r_rsp_err;

    logic [2:0]          w_next;
    logic [2:0]          w_op;
    logic [ADDR_WIDTH:0] w_depth_nx;
    logic                w_accept;
    logic                w_exec;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic                w_cap_a;
    logic                w_cap_b;
    logic                w_rsp_load;
    logic                w_rsp_err;
    logic [WIDTH-1:0]    w_rsp_data;
    logic [1:0]          w_delta;
    logic                w_we;
    logic [WIDTH-1:0]    w_wd;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE) && !rst;
    // In IDLE the opcode comes straight off the command port; later states use the latched copy.
    assign w_op      = (r_state == ST_IDLE) ? cmd_op : r_op;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RSP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign depth     = r_depth;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign stk_delta = w_delta;
    assign stk_we    = w_we;
    assign stk_wd    = w_wd;

    // Next-state, stack step and bookkeeping decode for the current cycle.
    always_comb begin
        w_next     = r_state;
        w_depth_nx = r_depth;
        w_delta    = DELTA_HOLD;
        w_we       = 1'b0;
        w_wd       = '0;
        w_exec     = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        w_cap_a    = 1'b0;
        w_cap_b    = 1'b0;
        w_rsp_load = 1'b0;
        w_rsp_err  = 1'b0;
        w_rsp_data = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (r_depth == MAX_FILL) begin
                                w_ovf_set = 1'b1;
                            end else begin
                                w_delta    = DELTA_INC;
                                w_we       = 1'b1;
                                w_wd       = cmd_data;
                                w_depth_nx = r_depth + D_ONE;
                            end
                        end
                        OP_REPLACE: begin
                            w_we = 1'b1;
                            w_wd = cmd_data;
                        end
                        OP_DROP2: begin
                            if (r_depth < D_TWO) begin
                                w_unf_set = 1'b1;
                            end else begin
                                w_delta    = DELTA_DEC2;
                                w_depth_nx = r_depth - D_TWO;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (r_depth == '0) begin
                                w_unf_set  = 1'b1;
                                w_rsp_load = 1'b1;
                                w_rsp_err  = 1'b1;
                                w_next     = ST_RSP;
                            end else if (r_quiet) begin
                                w_exec = 1'b1;
                            end else begin
                                w_next = ST_SETTLE;
                            end
                        end
                        OP_DUP: begin
                            if (r_depth == '0) begin
                                w_unf_set = 1'b1;
                            end else if (r_depth == MAX_FILL) begin
                                w_ovf_set = 1'b1;
                            end else if (r_quiet) begin
                                w_exec = 1'b1;
                            end else begin
                                w_next = ST_SETTLE;
                            end
                        end
                        OP_SWAP: begin
                            if (r_depth < D_TWO) begin
                                w_unf_set = 1'b1;
                            end else if (r_quiet) begin
                                w_exec = 1'b1;
                            end else begin
                                w_next = ST_SETTLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SETTLE:      w_next = ST_CAPT;
            ST_CAPT:        w_exec = 1'b1;
            ST_SWAP_POP: begin
                w_delta    = DELTA_DEC;
                w_depth_nx = r_depth - D_ONE;
                w_next     = ST_SWAP_SETTLE;
            end
            ST_SWAP_SETTLE: w_next = ST_SWAP_REP;
            ST_SWAP_REP: begin
                w_cap_b = 1'b1;
                w_we    = 1'b1;
                w_wd    = r_a;
                w_next  = ST_SWAP_PUSH;
            end
            ST_SWAP_PUSH: begin
                w_delta    = DELTA_INC;
                w_we       = 1'b1;
                w_wd       = r_b;
                w_depth_nx = r_depth + D_ONE;
                w_next     = ST_IDLE;
            end
            ST_RSP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default:        w_next = ST_IDLE;
        endcase

        // TOS-consuming ops share one action path, entered either directly
        // from IDLE when stk_rd is already valid or from CAPT after SETTLE.
        if (w_exec) begin
            case (w_op)
                OP_POP: begin
                    w_delta    = DELTA_DEC;
                    w_depth_nx = r_depth - D_ONE;
                    w_rsp_load = 1'b1;
                    w_rsp_data = stk_rd;
                    w_next     = ST_RSP;
                end
                OP_PEEK: begin
                    w_rsp_load = 1'b1;
                    w_rsp_data = stk_rd;
                    w_next     = ST_RSP;
                end
                OP_DUP: begin
                    w_delta    = DELTA_INC;
                    w_we       = 1'b1;
                    w_wd       = stk_rd;
                    w_depth_nx = r_depth + D_ONE;
                    w_next     = ST_IDLE;
                end
                OP_SWAP: begin
                    w_cap_a = 1'b1;
                    w_next  = ST_SWAP_POP;
                end
                default:   w_next = ST_IDLE;
            endcase
        end

        // Reset abandons any step in flight so the stack sees no movement.
        if (rst) begin
            w_delta = DELTA_HOLD;
            w_we    = 1'b0;
            w_wd    = '0;
        end
    end

    // State, depth, sticky flags, captured operands and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_NOP;
            r_depth    <= '0;
            r_quiet    <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_depth <= w_depth_nx;
            r_quiet <= (w_delta == DELTA_HOLD) && !w_we;
            if (w_accept)   r_op  <= cmd_op;
            if (w_cap_a)    r_a   <= stk_rd;
            if (w_cap_b)    r_b   <= stk_rd;
            if (w_ovf_set)  r_ovf <= 1'b1;
            if (w_unf_set)  r_unf <= 1'b1;
            if (w_rsp_load) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer paired with a behavioural RAM-backed
// stack whose read data is registered (valid one quiet cycle after a step).
module tb_stack_sequencer;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  stk_delta;
    logic        stk_we;
    logic [15:0] stk_wd;
    logic [15:0] rd_q;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_step   = 0;

    stack_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_delta(stk_delta), .stk_we(stk_we), .stk_wd(stk_wd), .stk_rd(rd_q),
        .depth(depth), .overflow(overflow), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM-backed stack model: pointer step, write at post-step pointer, registered read.
    logic [15:0] mem [0:7];
    logic [2:0]  sp;
    logic [2:0]  sp_nx;
    always_comb begin
        case (stk_delta)
            2'b01:   sp_nx = sp + 3'd1;
            2'b11:   sp_nx = sp - 3'd1;
            2'b10:   sp_nx = sp - 3'd2;
            default: sp_nx = sp;
        endcase
    end
    always @(posedge clk) begin
        if (rst) begin
            sp <= 3'd0;
        end else begin
            sp <= sp_nx;
            if (stk_we) mem[sp_nx] <= stk_wd;
        end
        rd_q <= mem[sp];
    end

    // Activity counters on the stack port.
    always @(posedge clk) begin
        if (stk_we) n_we <= n_we + 1;
        if (stk_delta != 2'b00) n_step <= n_step + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] data);
        int unsigned k = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: cmd_ready got 0 required 1 (op %0d)", op);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 16'h0;
    endtask

    task automatic get_rsp(output logic [15:0] data, output logic err);
        int unsigned k = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid got 0 required 1");
        end
        data = rsp_data;
        err  = rsp_err;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy got 1 required 0");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 16'hBEEF; rsp_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (stk_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_gated: got %b required 0", stk_we); end
        n_checks++; if (stk_delta !== 2'b00) begin n_fail++; $display("FAIL rst_delta_gated: got %b required 00", stk_delta); end
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0;
        tick();
        rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL rst_depth: got %0d required 0", depth); end
        n_checks++; if ({rsp_valid, rsp_err, overflow, underflow} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b required 0000", {rsp_valid, rsp_err, overflow, underflow}); end
        n_checks++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h required 0000", rsp_data); end
    endtask

    task automatic test_push_pop();
        logic [15:0] d; logic e;
        send(OP_PUSH, 16'h1111);
        send(OP_PUSH, 16'h2222);
        n_checks++; if (depth !== 4'd2) begin n_fail++; $display("FAIL pp_depth2: got %0d required 2", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h2222) begin n_fail++; $display("FAIL pp_pop_data: got %h required 2222", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL pp_pop_err: got %b required 0", e); end
        wait_idle();
        n_checks++; if (depth !== 4'd1) begin n_fail++; $display("FAIL pp_depth1: got %0d required 1", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h1111) begin n_fail++; $display("FAIL pp_pop2_data: got %h required 1111", d); end
        wait_idle();
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL pp_depth0: got %0d required 0", depth); end
    endtask

    task automatic test_swap();
        logic [15:0] d; logic e;
        send(OP_PUSH, 16'h000A);
        send(OP_PUSH, 16'h000B);
        send(OP_SWAP, 16'h0);
        wait_idle();
        n_checks++; if (depth !== 4'd2) begin n_fail++; $display("FAIL swap_depth: got %0d required 2", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h000A) begin n_fail++; $display("FAIL swap_pop1: got %h required 000a", d); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h000B) begin n_fail++; $display("FAIL swap_pop2: got %h required 000b", d); end
        wait_idle();
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL swap_depth0: got %0d required 0", depth); end
    endtask

    task automatic test_dup_replace();
        logic [15:0] d; logic e;
        send(OP_PUSH, 16'h0007);
        send(OP_DUP, 16'h0);
        wait_idle();
        n_checks++; if (depth !== 4'd2) begin n_fail++; $display("FAIL dup_depth: got %0d required 2", depth); end
        send(OP_REPLACE, 16'h0009);
        n_checks++; if (depth !== 4'd2) begin n_fail++; $display("FAIL rep_depth: got %0d required 2", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0009) begin n_fail++; $display("FAIL rep_pop: got %h required 0009", d); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0007) begin n_fail++; $display("FAIL dup_pop: got %h required 0007", d); end
        wait_idle();
    endtask

    task automatic test_peek_hold();
        logic [15:0] d; logic e;
        int unsigned k = 0;
        send(OP_PUSH, 16'h0005);
        send(OP_PEEK, 16'h0);
        while (!rsp_valid && k < 50) begin tick(); k++; end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL peek_valid_hold[%0d]: got %b required 1", i, rsp_valid); end
            n_checks++; if (rsp_data !== 16'h0005) begin n_fail++; $display("FAIL peek_data_hold[%0d]: got %h required 0005", i, rsp_data); end
            n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL peek_cmd_ready[%0d]: got %b required 0", i, cmd_ready); end
            tick();
        end
        get_rsp(d, e);
        n_checks++; if (depth !== 4'd1) begin n_fail++; $display("FAIL peek_depth: got %0d required 1", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0005) begin n_fail++; $display("FAIL peek_pop: got %h required 0005", d); end
        wait_idle();
    endtask

    task automatic test_underflow();
        logic [15:0] d; logic e;
        int steps0;
        steps0 = n_step;
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unf_err: got %b required 1", e); end
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL unf_data: got %h required 0000", d); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b required 1", underflow); end
        n_checks++; if (n_step !== steps0) begin n_fail++; $display("FAIL unf_no_step: got %0d steps required %0d", n_step, steps0); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL unf_ovf_clear: got %b required 0", overflow); end
        send(OP_PUSH, 16'h0033);
        steps0 = n_step;
        send(OP_DROP2, 16'h0);
        tick();
        tick();
        n_checks++; if (depth !== 4'd1) begin n_fail++; $display("FAIL drop2_rej_depth: got %0d required 1", depth); end
        n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL drop2_rej_idle: got %b required 00", {rsp_valid, busy}); end
        n_checks++; if (n_step !== steps0) begin n_fail++; $display("FAIL drop2_rej_step: got %0d required %0d", n_step, steps0); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0033) begin n_fail++; $display("FAIL drop2_rej_pop: got %h required 0033", d); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b required 1", underflow); end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [15:0] d; logic e;
        int we0;
        for (int i = 0; i < 7; i++) send(OP_PUSH, 16'h0100 + 16'(i));
        n_checks++; if (depth !== 4'd7) begin n_fail++; $display("FAIL ovf_full_depth: got %0d required 7", depth); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b required 0", overflow); end
        we0 = n_we;
        send(OP_PUSH, 16'hDEAD);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        n_checks++; if (depth !== 4'd7) begin n_fail++; $display("FAIL ovf_depth: got %0d required 7", depth); end
        n_checks++; if (n_we !== we0) begin n_fail++; $display("FAIL ovf_no_we: got %0d writes required %0d", n_we, we0); end
        send(OP_DROP2, 16'h0);
        n_checks++; if (depth !== 4'd5) begin n_fail++; $display("FAIL drop2_depth: got %0d required 5", depth); end
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0104) begin n_fail++; $display("FAIL drop2_pop: got %h required 0104", d); end
        send(OP_DROP2, 16'h0);
        send(OP_DROP2, 16'h0);
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d required 0", depth); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic e;
        int unsigned k = 0;
        int we0;
        send(OP_PUSH, 16'h0001);
        send(OP_PUSH, 16'h0002);
        send(OP_SWAP, 16'h0);
        while (stk_delta !== 2'b11 && k < 50) begin tick(); k++; end
        tick();
        n_checks++; if ({busy, stk_we, stk_delta} !== 4'b1000) begin n_fail++; $display("FAIL mid_in_settle: got %b required 1000", {busy, stk_we, stk_delta}); end
        rst = 1'b1;
        we0 = n_we;
        tick();
        rst = 1'b0;
        n_checks++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL mid_idle: got %b required 10", {cmd_ready, busy}); end
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL mid_depth: got %0d required 0", depth); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL mid_flags: got %b required 00", {overflow, underflow}); end
        tick(); tick(); tick();
        n_checks++; if (n_we !== we0) begin n_fail++; $display("FAIL mid_no_we: got %0d writes required %0d", n_we, we0); end
        send(OP_PUSH, 16'h0044);
        send(OP_POP, 16'h0);
        get_rsp(d, e);
        n_checks++; if (d !== 16'h0044) begin n_fail++; $display("FAIL mid_recover: got %h required 0044", d); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0; rsp_ready = 1'b0;
        test_reset();
        test_push_pop();
        test_swap();
        test_dup_replace();
        test_peek_hold();
        test_underflow();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
